fifo_read_ctrl: RTL and testbench

- Reader-side controller for the team's synchronous FIFO (FIFO_D=8, FIFO_W=32).
- Issues read_en pulses toward the FIFO when data is available and there is room downstream.
- Captures the FIFO's 1-cycle-latency data_out and presents it on a valid/ready stream through a small skid buffer.
- Also provides a flush mode that drains and discards FIFO contents, plus delivered/dropped word counters.

---
 rtl/fifo_rd_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 53 +++++
 rtl/fifo_read_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_read_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and default sizes for the FIFO read controller
package fifo_rd_pkg;

    localparam int FIFO_W = 32;
    localparam int BUF_D  = 3;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - small circular skid buffer between FIFO read data and the output stream
module fifo_rd_skid #(
    parameter int FIFO_W = 32,
    parameter int BUF_D  = 3,
    parameter int OCC_W  = $clog2(BUF_D + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [FIFO_W-1:0] push_data,
    input  logic              pop,
    input  logic              clear,
    output logic [OCC_W-1:0]  occupancy,
    output logic [FIFO_W-1:0] head,
    output logic              valid
);

    localparam int PTR_W = (BUF_D > 1) ? $clog2(BUF_D) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_D - 1);

    logic [FIFO_W-1:0] mem [BUF_D];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_pop;

    assign valid  = (occupancy != '0);
    assign do_pop = pop && valid;
    // Head reads as zero when empty so the stream data bus is quiet.
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            occupancy <= occupancy + OCC_W'(push) - OCC_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear && !reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO reader: issues read strobes, tags reads, streams or drops the returned words
import fifo_rd_pkg::*;

module fifo_read_ctrl #(
    parameter int FIFO_W = fifo_rd_pkg::FIFO_W,
    parameter int BUF_D  = fifo_rd_pkg::BUF_D,
    parameter int CNT_W  = fifo_rd_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush_req,
    input  logic              fifo_empty,
    output logic              fifo_read_en,
    input  logic [FIFO_W-1:0] fifo_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FIFO_W-1:0] m_data,
    output logic              busy,
    output logic              flush_done,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int OCC_W = $clog2(BUF_D + 1);
    localparam logic [OCC_W:0] DEPTH = (OCC_W + 1)'(BUF_D);

    rd_state_e         state;
    logic              inflight;
    logic              tag;
    logic [OCC_W-1:0]  occupancy;
    logic              buf_valid;
    logic [FIFO_W-1:0] buf_head;
    logic [OCC_W:0]    pending;
    logic              flush_go;
    logic              pop;
    logic              drop_word;
    logic              push;
    logic [CNT_W-1:0]  drop_add;

    assign pending   = {1'b0, occupancy} + (OCC_W + 1)'(inflight);
    assign flush_go  = flush_req && (state != FLUSH);
    assign pop       = buf_valid && m_ready;
    // Returning words are discarded once a flush has started, whatever their tag.
    assign drop_word = inflight && (tag || (state == FLUSH) || flush_go);
    assign push      = inflight && !drop_word;
    assign drop_add  = CNT_W'(drop_word)
                     + (flush_go ? CNT_W'(occupancy - OCC_W'(pop)) : '0);

    assign m_valid    = buf_valid;
    assign m_data     = buf_head;
    assign busy       = (state != IDLE) || buf_valid || inflight;
    assign flush_done = (state == FLUSH) && fifo_empty && !inflight;

    always_comb begin
        fifo_read_en = 1'b0;
        if (!reset && !fifo_empty) begin
            case (state)
                STREAM:  fifo_read_en = (pending < DEPTH);
                FLUSH:   fifo_read_en = 1'b1;
                default: fifo_read_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            inflight   <= 1'b0;
            tag        <= 1'b0;
            rd_count   <= '0;
            drop_count <= '0;
        end else begin
            inflight   <= fifo_read_en;
            tag        <= (state == FLUSH) || flush_go;
            drop_count <= drop_count + drop_add;
            if (pop) begin
                rd_count <= rd_count + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (flush_req)   state <= FLUSH;
                    else if (enable) state <= STREAM;
                end
                STREAM: begin
                    if (flush_req)    state <= FLUSH;
                    else if (!enable) state <= IDLE;
                end
                FLUSH: begin
                    if (fifo_empty && !inflight) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_rd_skid #(
        .FIFO_W (FIFO_W),
        .BUF_D  (BUF_D),
        .OCC_W  (OCC_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (fifo_data_out),
        .pop       (pop),
        .clear     (flush_go),
        .occupancy (occupancy),
        .head      (buf_head),
        .valid     (buf_valid)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - scoreboard bench for fifo_read_ctrl against a behavioural FIFO
module tb_fifo_read_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush_req;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [31:0] fifo_data_out = 32'd0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        busy;
    logic        flush_done;
    logic [15:0] rd_count;
    logic [15:0] drop_count;

    fifo_read_ctrl #(.FIFO_W(32), .BUF_D(3), .CNT_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .flush_req     (flush_req),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .fifo_data_out (fifo_data_out),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .busy          (busy),
        .flush_done    (flush_done),
        .rd_count      (rd_count),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    logic [31:0] fmem [256];
    logic [7:0]  f_wr = 8'd0;
    logic [7:0]  f_rd = 8'd0;
    assign fifo_empty = (f_wr == f_rd);

    always @(posedge clk) begin
        if (fifo_read_en) begin
            fifo_data_out <= fmem[f_rd];
            f_rd          <= f_rd + 8'd1;
        end
    end

    logic [31:0] sb [$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_reads  = 0;
    int bad_rd   = 0;
    int n_fdone  = 0;
    int n_hs     = 0;
    int first_hs = -1;
    int last_hs  = -1;
    int load_id  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [31:0] w, input bit deliver);
        fmem[f_wr] = w;
        f_wr = f_wr + 8'd1;
        if (deliver) sb.push_back(w);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (fifo_read_en) begin
            n_reads++;
            if (fifo_empty) bad_rd++;
        end
        if (flush_done) n_fdone++;
        if (m_valid && m_ready) begin
            n_hs++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (sb.size() == 0) check("unexpected_word", m_data, 32'hxxxx_xxxx);
            else check("stream_data", m_data, sb.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush_req = 1'b0; m_ready = 1'b0;
        ticks(2);
        reset = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_read_en", fifo_read_en, 0);
        check("rst_busy", busy, 0);
        check("rst_m_data", m_data, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_drop_count", drop_count, 0);

        // streaming at one word per cycle
        enable = 1'b1; m_ready = 1'b1;
        ticks(2);
        load_id = cyc + 1;
        for (int k = 1; k <= 8; k++) load(32'h11 * k, 1'b1);
        n_hs = 0; first_hs = -1;
        ticks(14);
        check("stream_count", n_hs, 8);
        check("stream_first", first_hs, load_id + 2);
        check("stream_back2back", last_hs, first_hs + 7);
        check("stream_rd_count", rd_count, 8);

        // backpressure
        m_ready = 1'b0; n_reads = 0;
        for (int k = 1; k <= 8; k++) load(32'h11 * k, 1'b1);
        ticks(10);
        check("bp_reads", n_reads, 3);
        check("bp_m_valid", m_valid, 1);
        check("bp_head", m_data, 32'h11);
        tick();
        check("bp_head_stable", m_data, 32'h11);
        m_ready = 1'b1;
        ticks(15);
        check("bp_sb_empty", sb.size(), 0);
        check("bp_rd_count", rd_count, 16);

        // enable dropped with one read in flight
        n_reads = 0;
        load(32'hA1, 1'b1); load(32'hA2, 1'b0); load(32'hA3, 1'b0); load(32'hA4, 1'b0);
        enable = 1'b0;
        tick();
        check("en_busy_inflight", busy, 1);
        ticks(2);
        check("en_busy_after", busy, 0);
        check("en_m_valid", m_valid, 0);
        check("en_reads", n_reads, 1);
        check("en_rd_count", rd_count, 17);

        // flush with three buffered and five in the FIFO
        for (int k = 1; k <= 5; k++) load(32'hB0 + k, 1'b0);
        n_reads = 0; enable = 1'b1; m_ready = 1'b0;
        ticks(6);
        check("fl_reads", n_reads, 3);
        check("fl_head", m_data, 32'hA2);
        flush_req = 1'b1; enable = 1'b0; n_fdone = 0;
        tick();
        flush_req = 1'b0;
        ticks(20);
        check("fl_drop_count", drop_count, 8);
        check("fl_done_once", n_fdone, 1);
        check("fl_rd_count", rd_count, 17);
        check("fl_m_valid", m_valid, 0);
        check("fl_busy", busy, 0);

        // flush in the same cycle as a pop
        load(32'hC1, 1'b1); load(32'hC2, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        ticks(5);
        check("sim_head", m_data, 32'hC1);
        flush_req = 1'b1; m_ready = 1'b1; enable = 1'b0; n_fdone = 0;
        tick();
        flush_req = 1'b0; m_ready = 1'b0;
        ticks(5);
        check("sim_rd_count", rd_count, 18);
        check("sim_drop_count", drop_count, 9);
        check("sim_done_once", n_fdone, 1);
        check("sim_busy", busy, 0);

        // reset with two buffered and one in flight
        n_reads = 0;
        for (int k = 1; k <= 8; k++) load(32'hD0 + k, 1'b0);
        enable = 1'b1; m_ready = 1'b0;
        ticks(4);
        check("mr_reads", n_reads, 3);
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        check("mr_m_valid", m_valid, 0);
        check("mr_read_en", fifo_read_en, 0);
        check("mr_rd_count", rd_count, 0);
        check("mr_drop_count", drop_count, 0);
        check("mr_busy", busy, 0);
        check("mr_m_data", m_data, 0);
        m_ready = 1'b1;
        ticks(4);
        check("mr_no_ghost", m_valid, 0);
        check("mr_busy_after", busy, 0);

        check("read_while_empty", bad_rd, 0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
